// File: rtl/fp_pkg.sv
// Shared single-precision float constants and the complex-multiplier FSM state type.
package fp_pkg;

  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
  localparam logic [31:0] FP_PINF  = 32'h7F800000;
  localparam int          EXP_BIAS = 127;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    ADD_RE,
    ADD_IM,
    DONE
  } cmul_state_t;

endpackage

// File: rtl/add_sub_float.sv
// Combinational IEEE-754 single add/sub: aligns with guard/round/sticky, normalizes by
// leading-zero count, rounds RNE; denormals flush to signed zero.
module add_sub_float
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  function automatic logic [31:0] round_pack(input logic sign, input logic signed [10:0] exp_in,
                                             input logic [23:0] man, input logic g, input logic s);
    logic [24:0]        rsum;
    logic signed [10:0] ex;
    logic [31:0]        r;
    rsum = {1'b0, man} + {24'd0, g & (s | man[0])};
    ex   = exp_in;
    if (rsum[24]) begin
      rsum = 25'h0800000;
      ex   = ex + 11'sd1;
    end
    if (ex >= 11'sd255)    r = {sign, FP_PINF[30:0]};
    else if (ex <= 11'sd0) r = {sign, 31'd0};
    else                   r = {sign, ex[7:0], rsum[22:0]};
    return r;
  endfunction

  logic [31:0]        bx, big, sml;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]         d;
  logic [26:0]        mb, ms, ms_al, m;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [10:0] ex;

  always_comb begin
    bx     = {b[31] ^ sub, b[30:0]};
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);

    // Larger magnitude first so the subtraction below never goes negative.
    if (a[30:0] >= bx[30:0]) begin
      big = a;
      sml = bx;
    end else begin
      big = bx;
      sml = a;
    end
    d  = big[30:23] - sml[30:23];
    mb = {1'b1, big[22:0], 3'b000};
    ms = {1'b1, sml[22:0], 3'b000};
    if (d >= 8'd27) ms_al = 27'd1;
    else            ms_al = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};

    ex  = $signed({3'b000, big[30:23]});
    sum = '0;
    lz  = '0;
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms_al};
      if (sum[27]) begin
        m  = {sum[27:2], sum[1] | sum[0]};
        ex = ex + 11'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m  = mb - ms_al;
      lz = lzc27(m);
      m  = m << lz;
      ex = ex - $signed({6'd0, lz});
    end

    if (a_nan || b_nan)                             result = FP_QNAN;
    else if (a_inf && b_inf && (a[31] != bx[31]))   result = FP_QNAN;
    else if (a_inf)                                 result = a;
    else if (b_inf)                                 result = bx;
    else if (a_zero && b_zero)                      result = {a[31] & bx[31], 31'd0};
    else if (a_zero)                                result = bx;
    else if (b_zero)                                result = a;
    else if (m == 27'd0)                            result = 32'd0;
    else result = round_pack(big[31], ex, m[26:3], m[2], m[1] | m[0]);
  end

endmodule

// File: rtl/mul_float.sv
// Combinational IEEE-754 single multiply: RNE, denormals flushed to signed zero,
// overflow to signed Inf, NaN and Inf*0 produce the canonical quiet NaN.
module mul_float
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  function automatic logic [31:0] round_pack(input logic sign, input logic signed [10:0] exp_in,
                                             input logic [23:0] man, input logic g, input logic s);
    logic [24:0]        rsum;
    logic signed [10:0] ex;
    logic [31:0]        r;
    rsum = {1'b0, man} + {24'd0, g & (s | man[0])};
    ex   = exp_in;
    if (rsum[24]) begin
      rsum = 25'h0800000;
      ex   = ex + 11'sd1;
    end
    if (ex >= 11'sd255)   r = {sign, FP_PINF[30:0]};
    else if (ex <= 11'sd0) r = {sign, 31'd0};
    else                   r = {sign, ex[7:0], rsum[22:0]};
    return r;
  endfunction

  logic               sign;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic signed [10:0] ex;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex     = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - $signed(11'(EXP_BIAS));

    if (a_nan || b_nan)                          result = FP_QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) result = FP_QNAN;
    else if (a_inf || b_inf)                     result = {sign, FP_PINF[30:0]};
    else if (a_zero || b_zero)                   result = {sign, 31'd0};
    else if (prod[47])
      result = round_pack(sign, ex + 11'sd1, prod[47:24], prod[23], |prod[22:0]);
    else
      result = round_pack(sign, ex, prod[46:23], prod[22], |prod[21:0]);
  end

endmodule

// File: rtl/fp_cmul_seq.sv
// Sequential single-precision complex multiply y = a * w (or a * conj(w)) sharing one
// multiplier and one adder across a 7-cycle schedule.
module fp_cmul_seq
  import fp_pkg::*;
#(
  parameter bit CONJ_W = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] w_re,
  input  logic [31:0] w_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_re,
  output logic [31:0] y_im
);

  cmul_state_t state;
  logic [31:0] ar, ai, wr, wi;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] mul_a, mul_b, mul_y;
  logic [31:0] add_a, add_b, add_y;
  logic        add_sub;

  always_comb begin
    mul_a = ar;
    mul_b = wr;
    case (state)
      M1:      begin mul_a = ai; mul_b = wi; end
      M2:      begin mul_a = ar; mul_b = wi; end
      M3:      begin mul_a = ai; mul_b = wr; end
      default: begin mul_a = ar; mul_b = wr; end
    endcase
  end

  // ADD_RE negates p1 inside the adder; ADD_IM is a plain sum.
  always_comb begin
    add_a   = p0;
    add_b   = p1;
    add_sub = (state == ADD_RE);
    if (state == ADD_IM) begin
      add_a = p2;
      add_b = p3;
    end
  end

  mul_float u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_y)
  );

  add_sub_float u_add (
    .a      (add_a),
    .b      (add_b),
    .sub    (add_sub),
    .result (add_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      ar        <= '0;
      ai        <= '0;
      wr        <= '0;
      wi        <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ar       <= a_re;
          ai       <= a_im;
          wr       <= w_re;
          wi       <= w_im ^ {CONJ_W, 31'd0};
          in_ready <= 1'b0;
          state    <= M0;
        end
        M0: begin p0 <= mul_y; state <= M1; end
        M1: begin p1 <= mul_y; state <= M2; end
        M2: begin p2 <= mul_y; state <= M3; end
        M3: begin p3 <= mul_y; state <= ADD_RE; end
        ADD_RE: begin
          y_re  <= add_y;
          state <= ADD_IM;
        end
        ADD_IM: begin
          y_im      <= add_y;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cmul_seq.sv
// Directed bench for fp_cmul_seq: one instance plain, one with conjugated twiddle.
module tb_fp_cmul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] y_re0, y_im0, y_re1, y_im1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_cmul_seq #(.CONJ_W(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready), .y_re(y_re0), .y_im(y_im0)
  );

  fp_cmul_seq #(.CONJ_W(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready), .y_re(y_re1), .y_im(y_im1)
  );

  task automatic run_op(input logic [31:0] ar, ai, wr, wi, output int lat);
    a_re = ar; a_im = ai; w_re = wr; w_im = wi;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
    total++; if (y_re0 !== 32'h0) begin bad++; $display("FAIL reset_y_re got=%h want=00000000", y_re0); end
    total++; if (y_im0 !== 32'h0) begin bad++; $display("FAIL reset_y_im got=%h want=00000000", y_im0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", lat); end
    total++; if (y_re0 !== 32'hC0A00000) begin bad++; $display("FAIL basic_y_re got=%h want=c0a00000", y_re0); end
    total++; if (y_im0 !== 32'h41200000) begin bad++; $display("FAIL basic_y_im got=%h want=41200000", y_im0); end
    consume();
  endtask

  task automatic test_conj();
    int lat;
    run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, lat);
    total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL conj_out_valid got=%b want=1", out_valid1); end
    total++; if (y_re1 !== 32'h41300000) begin bad++; $display("FAIL conj_y_re got=%h want=41300000", y_re1); end
    total++; if (y_im1 !== 32'h40000000) begin bad++; $display("FAIL conj_y_im got=%h want=40000000", y_im1); end
    consume();
  endtask

  task automatic test_cancel();
    int lat;
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, lat);
    total++; if (y_re0 !== 32'h00000000) begin bad++; $display("FAIL cancel_y_re got=%h want=00000000", y_re0); end
    total++; if (y_im0 !== 32'h40000000) begin bad++; $display("FAIL cancel_y_im got=%h want=40000000", y_im0); end
    consume();
  endtask

  task automatic test_special();
    int lat;
    run_op(32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000, lat);
    total++; if (y_re0 !== 32'h7FC00000) begin bad++; $display("FAIL special_y_re got=%h want=7fc00000", y_re0); end
    total++; if (y_im0 !== 32'h7F800000) begin bad++; $display("FAIL special_y_im got=%h want=7f800000", y_im0); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    a_re = 32'h3F800000; a_im = 32'h40000000; w_re = 32'h40400000; w_im = 32'h40800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready0); end
    @(posedge clk); #1;
    // now in M1: new operands and an early out_ready must both be ignored
    a_re = 32'h3F800000; a_im = 32'h3F800000; w_re = 32'h3F800000; w_im = 32'h3F800000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_re = 32'h12345678; w_im = 32'h9ABCDEF0;
    lat = 2;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL bp_latency got=%0d want=6", lat); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || y_re0 !== 32'hC0A00000 || y_im0 !== 32'h41200000) begin
        bad++;
        $display("FAIL bp_stall%0d got v=%b r=%b y=%h,%h want v=1 r=0 y=c0a00000,41200000",
                 i, out_valid0, in_ready0, y_re0, y_im0);
      end
      @(posedge clk); #1;
    end
    consume();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready0); end
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL b2b_latency got=%0d want=6", lat); end
    total++; if (y_re0 !== 32'h00000000) begin bad++; $display("FAIL b2b_y_re got=%h want=00000000", y_re0); end
    total++; if (y_im0 !== 32'h40000000) begin bad++; $display("FAIL b2b_y_im got=%h want=40000000", y_im0); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    a_re = 32'h3F800000; a_im = 32'h40000000; w_re = 32'h40400000; w_im = 32'h40800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready0); end
    total++; if (y_re0 !== 32'h0 || y_im0 !== 32'h0) begin bad++; $display("FAIL rstmid_y got=%h,%h want=0,0", y_re0, y_im0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL rstmid_no_result got=%b want=0", out_valid0); end
    run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL rstmid_latency got=%0d want=6", lat); end
    total++; if (y_re0 !== 32'hC0A00000) begin bad++; $display("FAIL rstmid_y_re got=%h want=c0a00000", y_re0); end
    total++; if (y_im0 !== 32'h41200000) begin bad++; $display("FAIL rstmid_y_im got=%h want=41200000", y_im0); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conj();
    test_cancel();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
